// File: rtl/csr_trap_seq.sv
// csr_trap_seq: trap-entry / mret sequencer in front of the CSR write stage.
// A trap is broken into single-cycle CSR writes (mepc, mcause, optional
// mtval, mstatus clear, mstatus set) and then a one-cycle redirect. An mret
// uses only the two mstatus writes before its redirect. When the sequencer
// is idle and neither a trap nor an mret is pending, pipeline CSR requests
// pass straight through to the CSR stage in the same cycle.
// Optional feature macro: CSR_TRAP_MTVAL_EN adds the mtval write (T_TVAL).
// When it is undefined there is no mtval state, no tval capture register,
// and trap_tval_in is unused.

package csr_pkg;
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csrop_t;
endpackage

module csr_trap_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  csr_pkg::csrop_t       req_op_in,
    input  logic [ADDR_WIDTH-1:0] req_addr_in,
    input  logic [DATA_WIDTH-1:0] req_data_in,
    input  logic                  trap_valid_in,
    input  logic [DATA_WIDTH-1:0] trap_cause_in,
    input  logic [DATA_WIDTH-1:0] trap_pc_in,
    input  logic [DATA_WIDTH-1:0] trap_tval_in,
    output logic                  trap_ack_out,
    input  logic                  mret_valid_in,
    output logic                  mret_ack_out,
    input  logic                  mstatus_mie_in,
    input  logic                  mstatus_mpie_in,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    input  logic [DATA_WIDTH-1:0] mtvec_in,
    output csr_pkg::csrop_t       csr_op_out,
    output logic [DATA_WIDTH-1:0] csr_data_out,
    output logic [ADDR_WIDTH-1:0] csr_addr_out,
    output logic                  csr_wr_en_out,
    output logic                  redirect_valid_out,
    output logic [DATA_WIDTH-1:0] redirect_pc_out,
    output logic                  busy_out
);
    import csr_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MSTATUS = ADDR_WIDTH'(12'h300);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MEPC    = ADDR_WIDTH'(12'h341);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MCAUSE  = ADDR_WIDTH'(12'h342);
`ifdef CSR_TRAP_MTVAL_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTVAL   = ADDR_WIDTH'(12'h343);
`endif
    // MIE is bit 3, MPIE is bit 7 of mstatus.
    localparam logic [DATA_WIDTH-1:0] MSTATUS_IE_MASK = DATA_WIDTH'(8'h88);
    localparam logic [DATA_WIDTH-1:0] MSTATUS_MPIE    = DATA_WIDTH'(8'h80);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_T_EPC    = 3'd1,
        S_T_CAUSE  = 3'd2,
`ifdef CSR_TRAP_MTVAL_EN
        S_T_TVAL   = 3'd3,
`endif
        S_ST_CLR   = 3'd4,
        S_ST_SET   = 3'd5,
        S_REDIRECT = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic                  is_trap_q, is_trap_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  mie_q, mie_d;
    logic                  mpie_q, mpie_d;
    logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
`ifdef CSR_TRAP_MTVAL_EN
    logic [DATA_WIDTH-1:0] tval_q, tval_d;
`else
    // Input kept on the port for a uniform interface; it has no function here.
    logic                  unused_tval_s;
    assign unused_tval_s = ^trap_tval_in;
`endif

    logic                  req_ready_s;
    logic                  trap_ack_s;
    logic                  mret_ack_s;
    csrop_t                csr_op_s;
    logic [DATA_WIDTH-1:0] csr_data_s;
    logic [ADDR_WIDTH-1:0] csr_addr_s;
    logic                  csr_wr_en_s;
    logic                  redirect_valid_s;
    logic [DATA_WIDTH-1:0] redirect_pc_s;
    logic [DATA_WIDTH-1:0] trap_target_s;
    logic [DATA_WIDTH-1:0] vec_off_s;

    // Trap target: vectored offset only for interrupts in mode 1, else direct.
    always_comb begin
        if ((mtvec_in[1:0] == 2'b01) && cause_q[DATA_WIDTH-1]) begin
            vec_off_s = {cause_q[DATA_WIDTH-3:0], 2'b00};
        end else begin
            vec_off_s = '0;
        end
        trap_target_s = {mtvec_in[DATA_WIDTH-1:2], 2'b00} + vec_off_s;
    end

    // Next-state, capture and output decode for the sequencer.
    always_comb begin
        state_d          = state_q;
        is_trap_d        = is_trap_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        mepc_d           = mepc_q;
`ifdef CSR_TRAP_MTVAL_EN
        tval_d           = tval_q;
`endif
        req_ready_s      = 1'b0;
        trap_ack_s       = 1'b0;
        mret_ack_s       = 1'b0;
        csr_op_s         = CSR_OP_NONE;
        csr_data_s       = '0;
        csr_addr_s       = '0;
        csr_wr_en_s      = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = '0;

        case (state_q)
            S_IDLE: begin
                if (trap_valid_in) begin
                    trap_ack_s = 1'b1;
                    is_trap_d  = 1'b1;
                    cause_d    = trap_cause_in;
                    pc_d       = trap_pc_in;
                    mie_d      = mstatus_mie_in;
`ifdef CSR_TRAP_MTVAL_EN
                    tval_d     = trap_tval_in;
`endif
                    state_d    = S_T_EPC;
                end else if (mret_valid_in) begin
                    mret_ack_s = 1'b1;
                    is_trap_d  = 1'b0;
                    mpie_d     = mstatus_mpie_in;
                    mepc_d     = mepc_in;
                    state_d    = S_ST_CLR;
                end else begin
                    req_ready_s = 1'b1;
                    if (req_valid_in) begin
                        csr_op_s    = req_op_in;
                        csr_addr_s  = req_addr_in;
                        csr_data_s  = req_data_in;
                        csr_wr_en_s = 1'b1;
                    end else begin
                        csr_wr_en_s = 1'b0;
                    end
                end
            end
            S_T_EPC: begin
                csr_op_s    = CSR_OP_RW;
                csr_addr_s  = ADDR_MEPC;
                csr_data_s  = {pc_q[DATA_WIDTH-1:2], 2'b00};
                csr_wr_en_s = 1'b1;
                state_d     = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_op_s    = CSR_OP_RW;
                csr_addr_s  = ADDR_MCAUSE;
                csr_data_s  = cause_q;
                csr_wr_en_s = 1'b1;
`ifdef CSR_TRAP_MTVAL_EN
                state_d     = S_T_TVAL;
`else
                state_d     = S_ST_CLR;
`endif
            end
`ifdef CSR_TRAP_MTVAL_EN
            S_T_TVAL: begin
                csr_op_s    = CSR_OP_RW;
                csr_addr_s  = ADDR_MTVAL;
                csr_data_s  = tval_q;
                csr_wr_en_s = 1'b1;
                state_d     = S_ST_CLR;
            end
`endif
            S_ST_CLR: begin
                csr_op_s    = CSR_OP_RC;
                csr_addr_s  = ADDR_MSTATUS;
                csr_data_s  = MSTATUS_IE_MASK;
                csr_wr_en_s = 1'b1;
                state_d     = S_ST_SET;
            end
            S_ST_SET: begin
                csr_op_s    = CSR_OP_RS;
                csr_addr_s  = ADDR_MSTATUS;
                csr_wr_en_s = 1'b1;
                if (is_trap_q) begin
                    // Old MIE moves into MPIE; written even when zero.
                    csr_data_s = DATA_WIDTH'(mie_q) << 7;
                end else begin
                    // mret re-enables MPIE and restores MIE from MPIE.
                    csr_data_s = MSTATUS_MPIE | (DATA_WIDTH'(mpie_q) << 3);
                end
                state_d     = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid_s = 1'b1;
                if (is_trap_q) begin
                    redirect_pc_s = trap_target_s;
                end else begin
                    redirect_pc_s = {mepc_q[DATA_WIDTH-1:2], 2'b00};
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-operand registers; reset clears everything.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            is_trap_q <= 1'b0;
            cause_q   <= '0;
            pc_q      <= '0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            mepc_q    <= '0;
`ifdef CSR_TRAP_MTVAL_EN
            tval_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            is_trap_q <= is_trap_d;
            cause_q   <= cause_d;
            pc_q      <= pc_d;
            mie_q     <= mie_d;
            mpie_q    <= mpie_d;
            mepc_q    <= mepc_d;
`ifdef CSR_TRAP_MTVAL_EN
            tval_q    <= tval_d;
`endif
        end
    end

    // Outputs are forced low while reset is asserted, including the
    // combinational handshake paths that depend on live inputs.
    assign req_ready_out      = arst_n & req_ready_s;
    assign trap_ack_out       = arst_n & trap_ack_s;
    assign mret_ack_out       = arst_n & mret_ack_s;
    assign csr_op_out         = arst_n ? csr_op_s : CSR_OP_NONE;
    assign csr_data_out       = arst_n ? csr_data_s : '0;
    assign csr_addr_out       = arst_n ? csr_addr_s : '0;
    assign csr_wr_en_out      = arst_n & csr_wr_en_s;
    assign redirect_valid_out = arst_n & redirect_valid_s;
    assign redirect_pc_out    = arst_n ? redirect_pc_s : '0;
    assign busy_out           = arst_n & (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq: a scoreboard of expected CSR writes
// and redirects (with their cycle numbers) is filled as stimulus is driven
// and drained by a negedge monitor. Works with or without CSR_TRAP_MTVAL_EN.

module tb_csr_trap_seq;
    import csr_pkg::*;

`ifdef CSR_TRAP_MTVAL_EN
    localparam int TRAP_REDIR = 6;
`else
    localparam int TRAP_REDIR = 5;
`endif
    localparam int MRET_REDIR = 3;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    csrop_t      req_op_in = CSR_OP_NONE;
    logic [11:0] req_addr_in = 12'h000;
    logic [31:0] req_data_in = 32'h0;
    logic        trap_valid_in = 1'b0;
    logic [31:0] trap_cause_in = 32'h0;
    logic [31:0] trap_pc_in = 32'h0;
    logic [31:0] trap_tval_in = 32'h0;
    logic        trap_ack_out;
    logic        mret_valid_in = 1'b0;
    logic        mret_ack_out;
    logic        mstatus_mie_in = 1'b0;
    logic        mstatus_mpie_in = 1'b0;
    logic [31:0] mepc_in = 32'h0;
    logic [31:0] mtvec_in = 32'h0;
    csrop_t      csr_op_out;
    logic [31:0] csr_data_out;
    logic [11:0] csr_addr_out;
    logic        csr_wr_en_out;
    logic        redirect_valid_out;
    logic [31:0] redirect_pc_out;
    logic        busy_out;

    csr_trap_seq dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_op_in(req_op_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
        .trap_valid_in(trap_valid_in), .trap_cause_in(trap_cause_in),
        .trap_pc_in(trap_pc_in), .trap_tval_in(trap_tval_in), .trap_ack_out(trap_ack_out),
        .mret_valid_in(mret_valid_in), .mret_ack_out(mret_ack_out),
        .mstatus_mie_in(mstatus_mie_in), .mstatus_mpie_in(mstatus_mpie_in),
        .mepc_in(mepc_in), .mtvec_in(mtvec_in),
        .csr_op_out(csr_op_out), .csr_data_out(csr_data_out),
        .csr_addr_out(csr_addr_out), .csr_wr_en_out(csr_wr_en_out),
        .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        csrop_t      op;
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rd_exp_t;

    typedef struct {
        bit          is_trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
        bit          mie;
        bit          mpie;
        logic [31:0] mepc;
        logic [31:0] mtvec;
        logic [31:0] exp_pc;
    } vec_t;

    wr_exp_t wq[$];
    rd_exp_t rq[$];
    wr_exp_t mon_w;
    rd_exp_t mon_r;
    vec_t    vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter, advanced on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: drains the scoreboard as the DUT writes CSRs or redirects.
    always @(negedge clk) begin
        if (csr_wr_en_out) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                         csr_addr_out, csr_data_out, cyc);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_op", 64'(csr_op_out), 64'(mon_w.op));
                chk("wr_addr", 64'(csr_addr_out), 64'(mon_w.addr));
                chk("wr_data", 64'(csr_data_out), 64'(mon_w.data));
                chk("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
            end
        end else begin
            chk("idle_csr_zero", {30'h0, csr_op_out, csr_addr_out, csr_data_out}, 64'h0);
        end
        if (redirect_valid_out) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got pc %0h, expected none (cycle %0d)",
                         redirect_pc_out, cyc);
            end else begin
                mon_r = rq.pop_front();
                chk("redir_pc", 64'(redirect_pc_out), 64'(mon_r.pc));
                chk("redir_cycle", 64'(cyc), 64'(mon_r.cyc));
            end
        end else begin
            chk("redir_pc_zero", 64'(redirect_pc_out), 64'h0);
        end
    end

    task automatic push_trap(input logic [31:0] cause, input logic [31:0] pc,
                             input logic [31:0] tval, input bit mie, input int t,
                             input int nwr);
        wr_exp_t w[$];
        w.push_back('{op: CSR_OP_RW, addr: 12'h341, data: pc & ~32'h3, cyc: 0});
        w.push_back('{op: CSR_OP_RW, addr: 12'h342, data: cause, cyc: 0});
`ifdef CSR_TRAP_MTVAL_EN
        w.push_back('{op: CSR_OP_RW, addr: 12'h343, data: tval, cyc: 0});
`endif
        w.push_back('{op: CSR_OP_RC, addr: 12'h300, data: 32'h88, cyc: 0});
        w.push_back('{op: CSR_OP_RS, addr: 12'h300, data: mie ? 32'h80 : 32'h0, cyc: 0});
        for (int i = 0; i < w.size() && i < nwr; i++) begin
            w[i].cyc = t + 1 + i;
            wq.push_back(w[i]);
        end
    endtask

    task automatic push_mret(input bit mpie, input int t);
        wq.push_back('{op: CSR_OP_RC, addr: 12'h300, data: 32'h88, cyc: t + 1});
        wq.push_back('{op: CSR_OP_RS, addr: 12'h300, data: mpie ? 32'h88 : 32'h80, cyc: t + 2});
    endtask

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic drained(input string name);
        chk({name, "_wq_empty"}, 64'(wq.size()), 64'h0);
        chk({name, "_rq_empty"}, 64'(rq.size()), 64'h0);
        wq.delete();
        rq.delete();
    endtask

    task automatic do_req(input csrop_t op, input logic [11:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        req_valid_in = 1'b1;
        req_op_in    = op;
        req_addr_in  = addr;
        req_data_in  = data;
        wq.push_back('{op: op, addr: addr, data: data, cyc: cyc});
        @(negedge clk);
        chk("req_ready", 64'(req_ready_out), 64'h1);
        chk("req_busy", 64'(busy_out), 64'h0);
        @(posedge clk);
        #1;
        req_valid_in = 1'b0;
        @(negedge clk);
        chk("req_stay_idle", {62'h0, busy_out, req_ready_out}, 64'h1);
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        int last;
        @(posedge clk);
        #1;
        t = cyc;
        mtvec_in = v.mtvec;
        mstatus_mie_in = v.mie;
        mstatus_mpie_in = v.mpie;
        if (v.is_trap) begin
            trap_valid_in = 1'b1;
            trap_cause_in = v.cause;
            trap_pc_in    = v.pc;
            trap_tval_in  = v.tval;
            push_trap(v.cause, v.pc, v.tval, v.mie, t, 5);
            last = t + TRAP_REDIR;
        end else begin
            mret_valid_in = 1'b1;
            mepc_in       = v.mepc;
            push_mret(v.mpie, t);
            last = t + MRET_REDIR;
        end
        rq.push_back('{pc: v.exp_pc, cyc: last});
        @(negedge clk);
        chk("accept_acks", {62'h0, trap_ack_out, mret_ack_out},
            v.is_trap ? 64'h2 : 64'h1);
        @(posedge clk);
        #1;
        trap_valid_in   = 1'b0;
        mret_valid_in   = 1'b0;
        trap_cause_in   = $urandom;
        trap_pc_in      = $urandom;
        trap_tval_in    = $urandom;
        mepc_in         = $urandom;
        mstatus_mie_in  = ~v.mie;
        mstatus_mpie_in = ~v.mpie;
        @(negedge clk);
        chk("ack_pulse_busy", {61'h0, trap_ack_out, mret_ack_out, busy_out}, 64'h1);
        wait_until(last + 1);
        @(negedge clk);
        chk("back_idle", {62'h0, busy_out, req_ready_out}, 64'h1);
        drained("vec");
    endtask

    initial begin
        int t;
        int acc;
        vecs[0] = '{1'b1, 32'h0000_0002, 32'h0000_1006, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 32'h8000_0000, 32'h8000_0000};
        vecs[1] = '{1'b1, 32'h8000_0007, 32'h0000_2000, 32'h0000_0000, 1'b0, 1'b1, 32'h0, 32'h8000_0001, 32'h8000_001C};
        vecs[2] = '{1'b1, 32'h0000_0003, 32'h0000_3003, 32'h0000_1234, 1'b1, 1'b1, 32'h0, 32'h8000_0001, 32'h8000_0000};
        vecs[3] = '{1'b1, 32'h8000_0005, 32'h0000_4001, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 32'h4000_0002, 32'h4000_0000};
        vecs[4] = '{1'b1, 32'h8000_0003, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFD, 32'h0000_0008};
        vecs[5] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_2002, 32'h0000_0100, 32'h0000_2000};
        vecs[6] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3007, 32'h0000_0100, 32'h0000_3004};

        // Reset with every request input active: all outputs must stay low.
        trap_valid_in = 1'b1;
        mret_valid_in = 1'b1;
        req_valid_in  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_outputs", {58'h0, req_ready_out, trap_ack_out, mret_ack_out,
                                 busy_out, redirect_valid_out, csr_wr_en_out}, 64'h0);
        chk("rst_redirect_pc", 64'(redirect_pc_out), 64'h0);
        trap_valid_in = 1'b0;
        mret_valid_in = 1'b0;
        req_valid_in  = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {62'h0, busy_out, req_ready_out}, 64'h1);

        // Pipeline pass-through requests.
        do_req(CSR_OP_RS, 12'h305, 32'h0000_0004);
        do_req(CSR_OP_RW, 12'h340, $urandom);
        do_req(CSR_OP_RC, 12'h7C0, 32'h0000_00F0);

        // Table of trap / mret scenarios.
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Trap, mret and req together: trap wins, mret follows after REDIRECT.
        @(posedge clk);
        #1;
        t = cyc;
        mtvec_in        = 32'h0000_0100;
        trap_valid_in   = 1'b1;
        trap_cause_in   = 32'h0000_000B;
        trap_pc_in      = 32'h0000_0500;
        trap_tval_in    = 32'h0000_0077;
        mstatus_mie_in  = 1'b0;
        mret_valid_in   = 1'b1;
        mstatus_mpie_in = 1'b1;
        mepc_in         = 32'h0000_0604;
        req_valid_in    = 1'b1;
        req_op_in       = CSR_OP_RW;
        req_addr_in     = 12'h300;
        req_data_in     = 32'h1;
        push_trap(32'h0000_000B, 32'h0000_0500, 32'h0000_0077, 1'b0, t, 5);
        rq.push_back('{pc: 32'h0000_0100, cyc: t + TRAP_REDIR});
        push_mret(1'b1, t + TRAP_REDIR + 1);
        rq.push_back('{pc: 32'h0000_0604, cyc: t + TRAP_REDIR + 1 + MRET_REDIR});
        @(negedge clk);
        chk("simul_acks_ready", {61'h0, trap_ack_out, mret_ack_out, req_ready_out}, 64'h4);
        @(posedge clk);
        #1;
        trap_valid_in = 1'b0;
        req_valid_in  = 1'b0;
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            @(negedge clk);
            if (mret_ack_out) acc = cyc;
        end
        chk("mret_after_redirect", 64'(acc), 64'(t + TRAP_REDIR + 1));
        @(posedge clk);
        #1;
        mret_valid_in = 1'b0;
        wait_until(t + TRAP_REDIR + MRET_REDIR + 2);
        @(negedge clk);
        chk("simul_idle", 64'(busy_out), 64'h0);
        drained("simul");

        // Reset in the middle of a trap: only the first two writes may appear.
        @(posedge clk);
        #1;
        t = cyc;
        mtvec_in       = 32'h0000_0200;
        trap_valid_in  = 1'b1;
        trap_cause_in  = 32'h0000_0001;
        trap_pc_in     = 32'h0000_0044;
        trap_tval_in   = 32'h0000_0009;
        mstatus_mie_in = 1'b1;
        push_trap(32'h0000_0001, 32'h0000_0044, 32'h0000_0009, 1'b1, t, 2);
        @(negedge clk);
        chk("abort_trap_ack", 64'(trap_ack_out), 64'h1);
        @(posedge clk);
        #1;
        trap_valid_in = 1'b0;
        wait_until(t + 3);
        arst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {59'h0, req_ready_out, busy_out, redirect_valid_out,
                              csr_wr_en_out, trap_ack_out}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle", {62'h0, busy_out, req_ready_out}, 64'h1);
        drained("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
